// File: rtl/restoring_divider.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned per request.
// Results use truncating division; divide-by-zero and signed overflow finish early.
module restoring_divider #(
  parameter int NUM_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                isSigned,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  output logic                busy,
  output logic                done,
  output logic [NUM_SIZE-1:0] quotient,
  output logic [NUM_SIZE-1:0] remainder
);

  localparam int CNT_W = $clog2(NUM_SIZE);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_SIZE - 1);
  localparam logic [NUM_SIZE-1:0] MOST_NEG = {1'b1, {(NUM_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_SIZE-1:0] qreg;
  logic [NUM_SIZE-1:0] dvsr;
  logic [NUM_SIZE-1:0] prem;
  logic                negq;
  logic                negr;
  logic [NUM_SIZE:0]   shifted;
  logic [NUM_SIZE:0]   trial;
  logic                accept;
  logic                div_zero;
  logic                overflow;

  function automatic logic [NUM_SIZE-1:0] negate(input logic signed [NUM_SIZE-1:0] v);
    return -v;
  endfunction

  function automatic logic [NUM_SIZE-1:0] magnitude(input logic [NUM_SIZE-1:0] v,
                                                    input logic sgn);
    return (sgn && v[NUM_SIZE-1]) ? negate(v) : v;
  endfunction

  // A request is only taken when idle and not in the done cycle.
  assign accept   = (state == IDLE) && start && !done;
  assign div_zero = (dIn1 == '0);
  assign overflow = isSigned && (dIn0 == MOST_NEG) && (dIn1 == '1);

  always_comb begin
    shifted = {prem, qreg[NUM_SIZE-1]};
    trial   = shifted - {1'b0, dvsr};
  end

  // Datapath registers: magnitudes, partial remainder and quotient shifter.
  always_ff @(posedge clk) begin
    if (accept) begin
      qreg <= magnitude(dIn0, isSigned);
      dvsr <= magnitude(dIn1, isSigned);
      negq <= isSigned && (dIn0[NUM_SIZE-1] ^ dIn1[NUM_SIZE-1]);
      negr <= isSigned && dIn0[NUM_SIZE-1];
      prem <= '0;
    end else if (state == RUN) begin
      if (!trial[NUM_SIZE]) begin
        prem <= trial[NUM_SIZE-1:0];
        qreg <= {qreg[NUM_SIZE-2:0], 1'b1};
      end else begin
        prem <= shifted[NUM_SIZE-1:0];
        qreg <= {qreg[NUM_SIZE-2:0], 1'b0};
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            busy <= 1'b1;
            if (div_zero) begin
              quotient  <= '1;
              remainder <= dIn0;
              state     <= DONE;
            end else if (overflow) begin
              quotient  <= dIn0;
              remainder <= '0;
              state     <= DONE;
            end else begin
              cnt   <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          quotient  <= negq ? negate(qreg) : qreg;
          remainder <= negr ? negate(prem) : prem;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: directed cases plus random requests
// checked against plain-arithmetic truncating division.
module tb_restoring_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        isSigned = 1'b0;
  logic [31:0] dIn0 = '0;
  logic [31:0] dIn1 = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  restoring_divider #(.NUM_SIZE(32)) dut (
    .clk(clk), .rst(rst), .start(start), .isSigned(isSigned),
    .dIn0(dIn0), .dIn1(dIn1), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          tdone;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: truncating division with the two early-exit cases.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit s,
                       output logic [31:0] q, output logic [31:0] r, output int lat);
    int sa, sb_;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 0; lat = 1;
    end else if (s) begin
      sa = a; sb_ = b;
      q = sa / sb_; r = sa % sb_; lat = 34;
    end else begin
      q = a / b; r = a % b; lat = 34;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("done_cycle", cyc, e.tdone);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Called #1 after a rising edge: strobe start for one sampling edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input bit s, output int t);
    start = 1'b1; dIn0 = a; dIn1 = b; isSigned = s;
    @(posedge clk); #1;
    start = 1'b0;
    dIn0 = $urandom; dIn1 = $urandom; isSigned = $urandom_range(0, 1);
    t = cyc;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input bit s, input int t);
    exp_t e;
    int lat;
    model(a, b, s, e.q, e.r, lat);
    e.tdone = t + lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, output int t);
    @(posedge clk); #1;
    drive(a, b, s, t);
    push(a, b, s, t);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!busy && !done) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  int t, t2, bcnt;
  logic [31:0] ra, rb;
  bit rs;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    rst = 1'b0;

    // Unsigned 100/7 with busy-duration measurement.
    issue(32'd100, 32'd7, 1'b0, t);
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) bcnt++;
    end
    chk("busy_cycles", bcnt, 32'd34);
    wait_idle();

    issue(32'hFFFF_FF9C, 32'd7, 1'b1, t);            wait_idle();
    issue(32'd100, 32'hFFFF_FFF9, 1'b1, t);          wait_idle();
    issue(32'h1234_5678, 32'd0, 1'b0, t);            wait_idle();
    issue(32'h1234_5678, 32'd0, 1'b1, t);            wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, t);    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, t);    wait_idle();

    // Handshake: starts while busy and during done are ignored.
    issue(32'd1000, 32'd33, 1'b0, t);
    repeat (4) @(posedge clk);
    #1;
    drive(32'd77, 32'd5, 1'b0, t2);
    for (int i = 0; i < 100 && cyc < t + 34; i++) begin
      @(posedge clk); #1;
    end
    drive(32'd999, 32'd3, 1'b1, t2);
    drive(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, t2);
    push(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, t2);
    wait_idle();

    // Reset in the middle of a run.
    issue(32'h0BAD_F00D, 32'd13, 1'b0, t);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", done_seen, 32'd0);
    issue(32'hFFFF_FFFF, 32'h10, 1'b0, t);
    wait_idle();

    // Random requests with biased corner operands.
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = $urandom_range(1, 16);
        4: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      issue(ra, rb, rs, t);
      wait_idle();
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
